candidate_matcher: RTL and testbench

Downstream consumer of the ASCII letter-counter chain in the brute-force cracker. Drives the chain's enable, compares each generated candidate word against a loaded target password and counts attempts. Stops the chain on a match or after the most-significant counter wraps. Reports the result with a sticky status.

---
 rtl/cracker_pkg.sv | 18 +
 rtl/candidate_matcher_if.sv | 29 ++
 rtl/word_compare.sv | 28 ++
 rtl/candidate_matcher.sv | 154 +++++++++++++++
 tb/tb_candidate_matcher.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/cracker_pkg.sv
// Shared definitions for the brute-force cracker blocks.
// Holds the matcher state encoding and the ASCII letter bounds used by
// both the target validation and the candidate comparison.
package cracker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    SEARCH,
    FOUND,
    EXHAUSTED
  } state_t;

  localparam logic [7:0] LETTER_A = 8'h61;
  localparam logic [7:0] LETTER_Z = 8'h7A;
  localparam int         ALPHABET = 26;

endpackage

// File: rtl/candidate_matcher_if.sv
// Link between the candidate matcher and the ASCII letter-counter chain.
// Signals:
//   candidate     - current word from the chain, letter 0 (fastest) in [7:0]
//   lastWrap      - wrap flag of the most-significant counter
//   counterEnable - enable for the whole chain
// Modports:
//   master - the matcher: drives counterEnable, consumes the chain outputs
//   slave  - the counter chain
interface candidate_matcher_if #(
  parameter int LENGTH = 4
);

  logic [8*LENGTH-1:0] candidate;
  logic                lastWrap;
  logic                counterEnable;

  modport master (
    output counterEnable,
    input  candidate,
    input  lastWrap
  );

  modport slave (
    input  counterEnable,
    output candidate,
    output lastWrap
  );

endinterface

// File: rtl/word_compare.sv
// Combinational word checker.
// Ports:
//   wordA - word whose letters must all lie in a..z
//   wordB - word compared letter by letter against wordA
//   hit   - 1 when wordA equals wordB and every letter of wordA is a..z
// Feeding the same word on both inputs turns it into a pure range check.
module word_compare
  import cracker_pkg::*;
#(
  parameter int LENGTH = 4
) (
  input  logic [8*LENGTH-1:0] wordA,
  input  logic [8*LENGTH-1:0] wordB,
  output logic                hit
);

  always_comb begin
    hit = 1'b1;
    for (int i = 0; i < LENGTH; i++) begin
      if ((wordA[8*i +: 8] != wordB[8*i +: 8]) ||
          (wordA[8*i +: 8] < LETTER_A) ||
          (wordA[8*i +: 8] > LETTER_Z)) begin
        hit = 1'b0;
      end
    end
  end

endmodule

// File: rtl/candidate_matcher.sv
// Candidate matcher: runs the letter-counter chain, compares every
// generated word with a latched target and counts the attempts.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   start         - pulse that begins a search (only with a valid a..z target)
//   target        - target password, letter 0 in [7:0]
//   chain         - counter chain link (candidate, lastWrap, counterEnable)
//   busy          - search in progress (WARMUP or SEARCH)
//   found         - sticky, the target was matched
//   exhausted     - sticky, the chain wrapped without a match
//   matchedWord   - the candidate that matched
//   attempts      - candidates compared in the current or last search
module candidate_matcher
  import cracker_pkg::*;
#(
  parameter int LENGTH     = 4,
  parameter int PIPE_DELAY = 2,
  parameter int ATTEMPT_W  = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [8*LENGTH-1:0]   target,
  candidate_matcher_if.master   chain,
  output logic                  busy,
  output logic                  found,
  output logic                  exhausted,
  output logic [8*LENGTH-1:0]   matchedWord,
  output logic [ATTEMPT_W-1:0]  attempts
);

  localparam int WORD_W = 8 * LENGTH;
  localparam int WARM_W = (PIPE_DELAY > 1) ? $clog2(PIPE_DELAY) : 1;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   target_q, target_d;
  logic [WARM_W-1:0]   warmCnt_q, warmCnt_d;
  logic                busy_q, busy_d;
  logic                enable_q, enable_d;
  logic                found_q, found_d;
  logic                exhausted_q, exhausted_d;
  logic [WORD_W-1:0]   matchedWord_q, matchedWord_d;
  logic [ATTEMPT_W-1:0] attempts_q, attempts_d;

  logic targetValid;
  logic isMatch;
  logic startAccept;

  word_compare #(.LENGTH(LENGTH)) u_validate (
    .wordA (target),
    .wordB (target),
    .hit   (targetValid)
  );

  word_compare #(.LENGTH(LENGTH)) u_match (
    .wordA (chain.candidate),
    .wordB (target_q),
    .hit   (isMatch)
  );

  // A start is only honoured when no search is running.
  assign startAccept = start && targetValid &&
                       ((state_q == IDLE) || (state_q == FOUND) || (state_q == EXHAUSTED));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, FOUND, EXHAUSTED: begin
        if (startAccept) state_d = WARMUP;
      end
      WARMUP: begin
        if (warmCnt_q == WARM_W'(PIPE_DELAY - 1)) state_d = SEARCH;
      end
      SEARCH: begin
        // A match takes priority over a simultaneous wrap.
        if (isMatch)             state_d = FOUND;
        else if (chain.lastWrap) state_d = EXHAUSTED;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    target_d      = target_q;
    warmCnt_d     = warmCnt_q;
    found_d       = found_q;
    exhausted_d   = exhausted_q;
    matchedWord_d = matchedWord_q;
    attempts_d    = attempts_q;

    if (startAccept) begin
      target_d      = target;
      warmCnt_d     = '0;
      found_d       = 1'b0;
      exhausted_d   = 1'b0;
      matchedWord_d = '0;
      attempts_d    = '0;
    end else if (state_q == WARMUP) begin
      warmCnt_d = warmCnt_q + WARM_W'(1);
    end else if (state_q == SEARCH) begin
      // The matching candidate itself is counted; the count saturates.
      attempts_d = (&attempts_q) ? attempts_q : attempts_q + ATTEMPT_W'(1);
      if (isMatch) begin
        matchedWord_d = chain.candidate;
        found_d       = 1'b1;
      end else if (chain.lastWrap) begin
        exhausted_d = 1'b1;
      end
    end

    // Registered from the next state so the chain stops on the same
    // cycle found/exhausted appear, leaving it one step past the match.
    busy_d   = (state_d == WARMUP) || (state_d == SEARCH);
    enable_d = busy_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      target_q      <= '0;
      warmCnt_q     <= '0;
      busy_q        <= 1'b0;
      enable_q      <= 1'b0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      matchedWord_q <= '0;
      attempts_q    <= '0;
    end else begin
      target_q      <= target_d;
      warmCnt_q     <= warmCnt_d;
      busy_q        <= busy_d;
      enable_q      <= enable_d;
      found_q       <= found_d;
      exhausted_q   <= exhausted_d;
      matchedWord_q <= matchedWord_d;
      attempts_q    <= attempts_d;
    end
  end

  assign chain.counterEnable = enable_q;
  assign busy                = busy_q;
  assign found               = found_q;
  assign exhausted           = exhausted_q;
  assign matchedWord         = matchedWord_q;
  assign attempts            = attempts_q;

endmodule

// File: tb/tb_candidate_matcher.sv
// Bench for candidate_matcher with a two-letter behavioural counter chain
// whose candidate output trails the counters by two pipeline stages.
module tb_candidate_matcher;
  import cracker_pkg::*;

  localparam int LENGTH     = 2;
  localparam int PIPE_DELAY = 2;
  localparam int ATTEMPT_W  = 24;
  localparam int KEYSPACE   = ALPHABET * ALPHABET;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 start;
  logic [15:0]          target;
  logic                 busy, found, exhausted;
  logic [15:0]          matchedWord;
  logic [ATTEMPT_W-1:0] attempts;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic        found;
    logic        exhausted;
    logic [15:0] word;
    int          attempts;
  } result_t;

  result_t expQ[$];

  // Chain model state
  int          chainIdx = 0;
  int          pipe1    = 0;
  int          pipe2    = 0;
  logic        chainReset;
  logic        forceWrapEn;
  logic [15:0] forceWrapWord;

  candidate_matcher_if #(.LENGTH(LENGTH)) chainBus ();

  candidate_matcher #(
    .LENGTH     (LENGTH),
    .PIPE_DELAY (PIPE_DELAY),
    .ATTEMPT_W  (ATTEMPT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .target      (target),
    .chain       (chainBus),
    .busy        (busy),
    .found       (found),
    .exhausted   (exhausted),
    .matchedWord (matchedWord),
    .attempts    (attempts)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] wordOf(input int i);
    logic [7:0] lo, hi;
    lo = 8'(int'(LETTER_A) + (i % ALPHABET));
    hi = 8'(int'(LETTER_A) + (i / ALPHABET));
    return {hi, lo};
  endfunction

  function automatic int indexOf(input logic [15:0] w);
    return (int'(w[15:8]) - int'(LETTER_A)) * ALPHABET + (int'(w[7:0]) - int'(LETTER_A));
  endfunction

  // Counters advance only when enabled; the two output stages run freely,
  // so the first candidate of a search is the position held at its start.
  always @(posedge clock) begin
    if (chainReset) begin
      chainIdx <= 0;
      pipe1    <= 0;
      pipe2    <= 0;
    end else begin
      if (chainBus.counterEnable) chainIdx <= (chainIdx == KEYSPACE - 1) ? 0 : chainIdx + 1;
      pipe1 <= chainIdx;
      pipe2 <= pipe1;
    end
  end

  assign chainBus.candidate = wordOf(pipe2);
  assign chainBus.lastWrap  = (pipe2 == KEYSPACE - 1) ||
                              (forceWrapEn && (chainBus.candidate == forceWrapWord));

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one start pulse; for a valid target the expected outcome is
  // derived from the chain position at the moment the start is taken.
  task automatic applyStimulus(input logic [15:0] tgt, input bit expectResult);
    result_t r;
    int      s, t;
    @(negedge clock);
    target = tgt;
    start  = 1'b1;
    if (expectResult) begin
      s = chainIdx;
      t = indexOf(tgt);
      if (t >= s) begin
        r.found = 1'b1; r.exhausted = 1'b0; r.word = tgt; r.attempts = t - s + 1;
      end else begin
        r.found = 1'b0; r.exhausted = 1'b1; r.word = 16'h0; r.attempts = KEYSPACE - s;
      end
      expQ.push_back(r);
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic waitResult(input string tag);
    result_t r;
    bit      done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clock);
      if (found || exhausted) done = 1'b1;
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    if (expQ.size() == 0) begin
      checkOutput({tag, "_queue"}, 32'd0, 32'd1);
      return;
    end
    r = expQ.pop_front();
    if (!done) return;
    checkOutput({tag, "_found"},     32'(found),                  32'(r.found));
    checkOutput({tag, "_exhausted"}, 32'(exhausted),              32'(r.exhausted));
    checkOutput({tag, "_word"},      32'(matchedWord),            32'(r.word));
    checkOutput({tag, "_attempts"},  32'(attempts),               32'(r.attempts));
    checkOutput({tag, "_enable"},    32'(chainBus.counterEnable), 32'd0);
    checkOutput({tag, "_busy"},      32'(busy),                   32'd0);
  endtask

  task automatic resetChain();
    @(negedge clock);
    chainReset = 1'b1;
    @(negedge clock);
    chainReset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    target        = 16'h0;
    chainReset    = 1'b1;
    forceWrapEn   = 1'b0;
    forceWrapWord = 16'h0;
    repeat (3) @(negedge clock);
    reset      = 1'b0;
    chainReset = 1'b0;

    checkOutput("rst_enable",    32'(chainBus.counterEnable), 32'd0);
    checkOutput("rst_busy",      32'(busy),                   32'd0);
    checkOutput("rst_found",     32'(found),                  32'd0);
    checkOutput("rst_exhausted", 32'(exhausted),              32'd0);
    checkOutput("rst_word",      32'(matchedWord),            32'd0);
    checkOutput("rst_attempts",  32'(attempts),               32'd0);

    // "a{" : second letter 0x7B is outside a..z, start must be ignored
    applyStimulus(16'h7B61, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bad_busy",   32'(busy),                   32'd0);
      checkOutput("bad_enable", 32'(chainBus.counterEnable), 32'd0);
      @(negedge clock);
    end
    checkOutput("bad_attempts", 32'(attempts),    32'd0);
    checkOutput("bad_word",     32'(matchedWord), 32'd0);

    // "ba" from "aa": second candidate
    applyStimulus(16'h6162, 1'b1);
    waitResult("ba");

    // Restart with "ab": results clear, chain resumes where it stopped
    applyStimulus(16'h6261, 1'b1);
    checkOutput("restart_found",    32'(found),                  32'd0);
    checkOutput("restart_attempts", 32'(attempts),               32'd0);
    checkOutput("restart_word",     32'(matchedWord),            32'd0);
    checkOutput("restart_busy",     32'(busy),                   32'd1);
    checkOutput("restart_enable",   32'(chainBus.counterEnable), 32'd1);
    waitResult("ab");

    // "zz": last word of the keyspace, natural wrap arrives with the match
    resetChain();
    applyStimulus(16'h7A7A, 1'b1);
    waitResult("zz");

    // Forced wrap on the matching candidate: the match still wins
    resetChain();
    forceWrapWord = 16'h6162;
    forceWrapEn   = 1'b1;
    applyStimulus(16'h6162, 1'b1);
    waitResult("wrapmatch");
    forceWrapEn = 1'b0;

    // "aa" already passed by the chain: search runs to the wrap
    applyStimulus(16'h6161, 1'b1);
    waitResult("exhaust");

    // Invalid start in EXHAUSTED leaves the sticky result alone
    applyStimulus(16'h617B, 1'b0);
    @(negedge clock);
    checkOutput("hold_exhausted", 32'(exhausted), 32'd1);
    checkOutput("hold_attempts",  32'(attempts),  32'(KEYSPACE - 4));
    checkOutput("hold_busy",      32'(busy),      32'd0);

    // "mm": reset five candidates into the search
    resetChain();
    applyStimulus(16'h6D6D, 1'b0);
    repeat (PIPE_DELAY + 5) @(negedge clock);
    checkOutput("mm_busy_before",     32'(busy),     32'd1);
    checkOutput("mm_attempts_before", 32'(attempts), 32'd5);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("mm_enable",   32'(chainBus.counterEnable), 32'd0);
    checkOutput("mm_busy",     32'(busy),                   32'd0);
    checkOutput("mm_attempts", 32'(attempts),               32'd0);
    checkOutput("mm_found",    32'(found),                  32'd0);
    @(negedge clock);
    checkOutput("mm_idle_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
